// File: rtl/cms_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : cms_stream_receiver
// Description : Accepts wide AXI-Stream trace beats and serialises each one
//               into WORD_WIDTH words, least-significant slice first.
//               Optional frame-length check: CMS_RX_INTERVAL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cms_stream_receiver #(
    parameter int AXI_DATA_WIDTH = 1024,
    parameter int WORD_WIDTH     = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    output logic [WORD_WIDTH-1:0]     out_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [31:0]               beat_count,
    output logic                      interval_error,
    input  logic                      clear_error
);

    localparam int c_N  = AXI_DATA_WIDTH / WORD_WIDTH;
    localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_N - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    generate
        if ((AXI_DATA_WIDTH % WORD_WIDTH) != 0) begin : g_width_check
            $error("AXI_DATA_WIDTH must be a multiple of WORD_WIDTH");
        end
    endgenerate

    state_t                    r_state;
    state_t                    w_state_next;
    logic [AXI_DATA_WIDTH-1:0] r_buf;
    logic                      r_last;
    logic [c_IW-1:0]           r_idx;
    logic [31:0]               r_beat_count;
    logic [WORD_WIDTH-1:0]     w_words [c_N];
    logic                      w_last_word;
    logic                      w_word_xfer;
    logic                      w_accept;

    generate
        for (genvar gi = 0; gi < c_N; gi++) begin : g_slice
            assign w_words[gi] = r_buf[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    assign out_valid   = (r_state == ST_DRAIN);
    assign w_last_word = out_valid && (r_idx == c_LAST_IDX);
    assign w_word_xfer = out_valid && out_ready;
    // Refill in the same cycle the final word leaves, so beats stream with no bubble.
    assign S_AXIS_tready = rst_n && ((r_state == ST_EMPTY) || (w_last_word && out_ready));
    assign w_accept    = S_AXIS_tvalid && S_AXIS_tready;
    assign out_word    = w_words[r_idx];
    assign out_last    = r_last && w_last_word;
    assign beat_count  = r_beat_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_word && w_word_xfer && !w_accept) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf        <= '0;
            r_last       <= 1'b0;
            r_idx        <= '0;
            r_beat_count <= '0;
        end else if (w_accept) begin
            r_buf        <= S_AXIS_tdata;
            r_last       <= S_AXIS_tlast;
            r_idx        <= '0;
            r_beat_count <= r_beat_count + 32'd1;
        end else if (w_word_xfer) begin
            r_idx <= w_last_word ? '0 : r_idx + c_IW'(1);
        end
    end

`ifdef CMS_RX_INTERVAL_CHECK_EN
    logic [31:0] r_frame_cnt;
    logic        r_interval_error;
    logic [31:0] w_n;
    logic        w_set_error;

    assign w_n         = r_frame_cnt + 32'd1;
    assign w_set_error = w_accept && (tlast_interval != 32'd0) &&
                         (S_AXIS_tlast ? (w_n != tlast_interval) : (w_n == tlast_interval));
    assign interval_error = r_interval_error;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt      <= '0;
            r_interval_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_frame_cnt <= S_AXIS_tlast ? 32'd0 : w_n;
            end
            // A new violation takes priority over a clear in the same cycle.
            if (w_set_error) begin
                r_interval_error <= 1'b1;
            end else if (clear_error) begin
                r_interval_error <= 1'b0;
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg   = clear_error ^ (^tlast_interval);
    assign interval_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cms_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_cms_stream_receiver
// Description : Scoreboard bench for cms_stream_receiver (directed beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cms_stream_receiver;

    localparam int c_DW = 1024;
    localparam int c_WW = 64;
    localparam int c_N  = c_DW / c_WW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            S_AXIS_tvalid;
    logic            S_AXIS_tready;
    logic [c_DW-1:0] S_AXIS_tdata;
    logic            S_AXIS_tlast;
    logic [31:0]     tlast_interval;
    logic [c_WW-1:0] out_word;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [31:0]     beat_count;
    logic            interval_error;
    logic            clear_error;

    always #5 clk = ~clk;

    cms_stream_receiver #(.AXI_DATA_WIDTH(c_DW), .WORD_WIDTH(c_WW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .S_AXIS_tvalid  (S_AXIS_tvalid),
        .S_AXIS_tready  (S_AXIS_tready),
        .S_AXIS_tdata   (S_AXIS_tdata),
        .S_AXIS_tlast   (S_AXIS_tlast),
        .tlast_interval (tlast_interval),
        .out_word       (out_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .beat_count     (beat_count),
        .interval_error (interval_error),
        .clear_error    (clear_error)
    );

    int            total = 0;
    int            bad   = 0;
    logic [c_WW:0] sb_q [$];
    logic [c_WW:0] sb_e;
    int            pops  = 0;
    int            cyc   = 0;
    int            vcnt  = 0;
    int            acc_cyc = 0;
    int            exp_beats = 0;
    logic          toggle_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int waited);
        total++;
        bad++;
        $display("FAIL %s: timed out after %0d cycles, required completion", name, waited);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ~out_ready;
        end
    end

    // Monitor: every presented word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            vcnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_word_sb_size", 64'(sb_q.size()), 64'd1);
            end else if (!out_ready) begin
                check("stall_hold_word", out_word, sb_q[0][c_WW-1:0]);
            end else begin
                sb_e = sb_q.pop_front();
                check("word", out_word, sb_e[c_WW-1:0]);
                check("last", 64'(out_last), 64'(sb_e[c_WW]));
                pops++;
            end
        end
    end

    function automatic logic [c_DW-1:0] mk_beat(input int b);
        logic [c_DW-1:0] d;
        for (int i = 0; i < c_N; i++) begin
            d[i*c_WW +: c_WW] = {8'hC0, 24'(b), 32'(i * 7 + 1)};
        end
        return d;
    endfunction

    task automatic send_beat(input logic [c_DW-1:0] d, input logic l, input bit keep);
        bit acc;
        int n;
        S_AXIS_tdata  = d;
        S_AXIS_tlast  = l;
        S_AXIS_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = S_AXIS_tready;
            if (acc) begin
                for (int i = 0; i < c_N; i++) begin
                    sb_q.push_back({l && (i == c_N - 1), d[i*c_WW +: c_WW]});
                end
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                n++;
                if (n > 200) begin
                    timeout_fail("send_beat", n);
                    break;
                end
            end
        end
        if (acc) begin
            acc_cyc = cyc;
            exp_beats++;
        end
        if (!keep) S_AXIS_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                timeout_fail("wait_drain", n);
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_beats = 0;
    endtask

    initial begin
        int c0, c1, c2, base, n;
        logic [c_DW-1:0] d;

        rst_n = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; S_AXIS_tlast = 1'b0;
        tlast_interval = 32'd0; out_ready = 1'b1; clear_error = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("tready_in_reset", 64'(S_AXIS_tready), 64'd0);
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_interval_error", 64'(interval_error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_reset", 64'(S_AXIS_tready), 64'd1);
        @(posedge clk); #1;

        // Single tlast beat: word 0 = 1, word 15 = F
        for (int i = 0; i < c_N; i++) d[i*c_WW +: c_WW] = 64'(i);
        d[63:0]      = 64'h1;
        d[1023:960]  = 64'hF;
        send_beat(d, 1'b1, 1'b0);
        check("first_word_visible", 64'(out_valid), 64'd1);
        wait_drain();
        check("beat_count_single", 64'(beat_count), 64'(exp_beats));

        // Three back-to-back beats, no bubble
        vcnt = 0;
        send_beat(mk_beat(1), 1'b0, 1'b1); c0 = acc_cyc;
        send_beat(mk_beat(2), 1'b0, 1'b1); c1 = acc_cyc;
        send_beat(mk_beat(3), 1'b1, 1'b0); c2 = acc_cyc;
        check("b2b_gap01", 64'(c1 - c0), 64'd16);
        check("b2b_gap12", 64'(c2 - c1), 64'd16);
        wait_drain();
        check("b2b_valid_cycles", 64'(vcnt), 64'd48);
        check("beat_count_b2b", 64'(beat_count), 64'(exp_beats));

        // out_ready alternating: 32 cycles per beat
        toggle_en = 1'b1;
        send_beat(mk_beat(4), 1'b0, 1'b1);
        send_beat(mk_beat(5), 1'b0, 1'b1); c1 = acc_cyc;
        send_beat(mk_beat(6), 1'b1, 1'b0); c2 = acc_cyc;
        check("toggle_gap", 64'(c2 - c1), 64'd32);
        wait_drain();
        toggle_en = 1'b0;
        @(posedge clk); #3;
        out_ready = 1'b1;
        check("beat_count_toggle", 64'(beat_count), 64'(exp_beats));

        // Reset mid-drain at word index 7
        base = pops;
        send_beat(mk_beat(7), 1'b1, 1'b0);
        n = 0;
        while (pops != base + 7 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("mid_drain_index7", n);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("tready_mid_reset", 64'(S_AXIS_tready), 64'd0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_beat_count", 64'(beat_count), 64'd0);
        check("mid_rst_out_last", 64'(out_last), 64'd0);
        sb_q.delete();
        exp_beats = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_mid_reset", 64'(S_AXIS_tready), 64'd1);
        @(posedge clk); #1;

        // Frame-length check
        tlast_interval = 32'd4;
`ifdef CMS_RX_INTERVAL_CHECK_EN
        send_beat(mk_beat(10), 1'b0, 1'b0);
        send_beat(mk_beat(11), 1'b0, 1'b0);
        check("ierr_before_short_tlast", 64'(interval_error), 64'd0);
        send_beat(mk_beat(12), 1'b1, 1'b0);
        check("ierr_short_frame", 64'(interval_error), 64'd1);
        clear_error = 1'b1;
        @(posedge clk); #1;
        clear_error = 1'b0;
        check("ierr_cleared", 64'(interval_error), 64'd0);
        for (int b = 0; b < 4; b++) send_beat(mk_beat(20 + b), b == 3, 1'b0);
        check("ierr_good_frame", 64'(interval_error), 64'd0);
        for (int b = 0; b < 3; b++) send_beat(mk_beat(30 + b), 1'b0, 1'b0);
        check("ierr_before_missing_tlast", 64'(interval_error), 64'd0);
        send_beat(mk_beat(33), 1'b0, 1'b0);
        check("ierr_missing_tlast", 64'(interval_error), 64'd1);
        wait_drain();
        check("beat_count_interval", 64'(beat_count), 64'(exp_beats));
        pulse_reset();
        tlast_interval = 32'd0;
        for (int b = 0; b < 6; b++) send_beat(mk_beat(40 + b), (b == 1) || (b == 5), 1'b0);
        check("ierr_disabled", 64'(interval_error), 64'd0);
`else
        clear_error = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(mk_beat(10 + b), b == 2, 1'b0);
        check("ierr_tied_short", 64'(interval_error), 64'd0);
        for (int b = 0; b < 4; b++) send_beat(mk_beat(20 + b), 1'b0, 1'b0);
        check("ierr_tied_missing", 64'(interval_error), 64'd0);
`endif
        wait_drain();
        check("beat_count_final", 64'(beat_count), 64'(exp_beats));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
